// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream source arbiter: FSM encoding,
// default widths and a small beat-parity helper.
package axis_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int DATA_W    = 32;
  localparam int DEF_N_SRC = 4;
  localparam int DEF_CNT_W = 16;

  // Running parity of accepted beats; 0 before a beat means that beat is odd-numbered.
  function automatic logic parity_next(input logic parity, input logic beat);
    return parity ^ beat;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N. Returns both one-hot and encoded grant.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant_oh,
  output logic [PW-1:0] grant_idx,
  output logic          valid
);

  logic [PW-1:0] pos_s;
  logic          hit_s;

  // Scan requests starting at the pointer; the first hit wins.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    valid     = 1'b0;
    pos_s     = '0;
    hit_s     = 1'b0;
    for (int off = 0; off < N; off++) begin
      pos_s           = PW'((int'(ptr) + off) % N);
      hit_s           = !valid && req[pos_s];
      grant_oh[pos_s] = grant_oh[pos_s] | hit_s;
      grant_idx       = hit_s ? pos_s : grant_idx;
      valid           = valid | hit_s;
    end
  end

endmodule

// File: rtl/axis_src_arb.sv
// Packet-granular round-robin arbiter merging N 32-bit AXI-Stream sources
// into one stream for the 32-to-64 packer, with odd-length checking and counters.
module axis_src_arb
  import axis_pkg::*;
#(
  parameter int N_SRC = DEF_N_SRC,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                      AXIS_ACLK,
  input  logic                      AXIS_ARESETN,
  input  logic [DATA_W*N_SRC-1:0]   S_AXIS_TDATA,
  input  logic [N_SRC-1:0]          S_AXIS_TVALID,
  input  logic [N_SRC-1:0]          S_AXIS_TLAST,
  output logic [N_SRC-1:0]          S_AXIS_TREADY,
  output logic [DATA_W-1:0]         M_AXIS_TDATA,
  output logic                      M_AXIS_TVALID,
  output logic                      M_AXIS_TLAST,
  input  logic                      M_AXIS_TREADY,
  output logic [DATA_W-1:0]         M_SRCDEST,
  input  logic [DATA_W*N_SRC-1:0]   SRCDEST_TBL,
  input  logic [N_SRC-1:0]          SRC_EN,
  output logic [N_SRC-1:0]          ERR_ODD,
  input  logic                      ERR_CLR,
  output logic [CNT_W*N_SRC-1:0]    PKT_CNT
);

  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  arb_state_e       state_r;
  arb_state_e       state_s;
  logic [PW-1:0]    ptr_r;
  logic [PW-1:0]    grant_r;
  logic [N_SRC-1:0] grant_oh_r;
  logic             parity_r;
  logic [N_SRC-1:0] err_r;

  logic [N_SRC-1:0] cand_s;
  logic [N_SRC-1:0] pick_oh_s;
  logic [PW-1:0]    pick_idx_s;
  logic             pick_valid_s;
  logic [PW-1:0]    next_ptr_s;
  logic             busy_s;
  logic             valid_sel_s;
  logic             last_sel_s;
  logic             xfer_s;
  logic             last_s;
  logic [N_SRC-1:0] err_set_s;

  logic [DATA_W-1:0] data_or_s [N_SRC+1];
  logic [DATA_W-1:0] sd_or_s   [N_SRC+1];

  assign cand_s = S_AXIS_TVALID & SRC_EN;

  rr_pick #(
    .N  (N_SRC),
    .PW (PW)
  ) u_rr_pick (
    .req       (cand_s),
    .ptr       (ptr_r),
    .grant_oh  (pick_oh_s),
    .grant_idx (pick_idx_s),
    .valid     (pick_valid_s)
  );

  // Granted-source selection as an AND-OR chain over the registered one-hot grant.
  assign data_or_s[0] = '0;
  assign sd_or_s[0]   = '0;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    logic [CNT_W-1:0] pkt_cnt_r;

    assign data_or_s[i+1] = data_or_s[i] |
                            (S_AXIS_TDATA[DATA_W*i +: DATA_W] & {DATA_W{grant_oh_r[i]}});
    assign sd_or_s[i+1]   = sd_or_s[i] |
                            (SRCDEST_TBL[DATA_W*i +: DATA_W] & {DATA_W{grant_oh_r[i]}});

    // Per-source forwarded packet counter, wrapping naturally.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
        pkt_cnt_r <= '0;
      end else if (last_s && grant_oh_r[i]) begin
        pkt_cnt_r <= pkt_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end

    assign PKT_CNT[CNT_W*i +: CNT_W] = pkt_cnt_r;
  end

  assign busy_s      = (state_r == ST_BUSY);
  assign valid_sel_s = |(S_AXIS_TVALID & grant_oh_r);
  assign last_sel_s  = |(S_AXIS_TLAST & grant_oh_r);
  assign xfer_s      = busy_s & valid_sel_s & M_AXIS_TREADY;
  assign last_s      = xfer_s & last_sel_s;
  assign next_ptr_s  = (grant_r == PW'(N_SRC - 1)) ? '0 : grant_r + {{(PW-1){1'b0}}, 1'b1};

  // A TLAST beat taken while parity is still 0 is the 1st/3rd/5th... word of the packet.
  assign err_set_s = {N_SRC{last_s && (parity_r == 1'b0)}} & grant_oh_r;

  // FSM state register.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and the pass-through stream outputs.
  always_comb begin
    state_s       = state_r;
    M_AXIS_TDATA  = '0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    M_SRCDEST     = '0;
    S_AXIS_TREADY = '0;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_s = ST_BUSY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        M_AXIS_TDATA  = data_or_s[N_SRC];
        M_AXIS_TVALID = valid_sel_s;
        M_AXIS_TLAST  = last_sel_s;
        M_SRCDEST     = sd_or_s[N_SRC];
        S_AXIS_TREADY = grant_oh_r & {N_SRC{M_AXIS_TREADY}};
        if (last_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BUSY;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Grant capture at arbitration; beat parity and pointer advance while busy.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      grant_r    <= '0;
      grant_oh_r <= '0;
      ptr_r      <= '0;
      parity_r   <= 1'b0;
    end else if (state_r == ST_IDLE) begin
      if (pick_valid_s) begin
        grant_r    <= pick_idx_s;
        grant_oh_r <= pick_oh_s;
        parity_r   <= 1'b0;
      end
    end else begin
      parity_r <= parity_next(parity_r, xfer_s);
      if (last_s) begin
        ptr_r <= next_ptr_s;
      end
    end
  end

  // Sticky odd-length flags; a same-cycle set overrides the clear.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      err_r <= '0;
    end else begin
      err_r <= (err_r & ~{N_SRC{ERR_CLR}}) | err_set_s;
    end
  end

  assign ERR_ODD = err_r;

endmodule

// File: doc/axis_src_arb.md
AXIS_SRC_ARB -- requirements
Module: axis_src_arb

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of 32-bit AXIS sources (2..8).
REQ-002 SHALL have parameter CNT_W, default 16, width of each per-source packet counter.
REQ-003 SHALL use one clock; reset is asynchronous and active-low (AXIS_ACLK, AXIS_ARESETN).
REQ-004 AXIS_ACLK  in  1  clock.
REQ-005 AXIS_ARESETN  in  1  async active-low reset.
REQ-006 S_AXIS_TDATA  in  32*N_SRC  source data, source i in bits [32i+31:32i].
REQ-007 S_AXIS_TVALID / S_AXIS_TLAST  in  N_SRC each  per-source valid / last.
REQ-008 S_AXIS_TREADY  out  N_SRC  per-source ready.
REQ-009 M_AXIS_TDATA / M_AXIS_TVALID / M_AXIS_TLAST  out  32/1/1  stream to 32-to-64 packer.
REQ-010 M_AXIS_TREADY  in  1  packer ready.
REQ-011 M_SRCDEST  out  32  SRCDEST word for the packer, from table of granted source.
REQ-012 SRCDEST_TBL  in  32*N_SRC  static per-source SRCDEST values.
REQ-013 SRC_EN  in  N_SRC  per-source arbitration enable.
REQ-014 ERR_ODD  out  N_SRC  sticky: source ended a packet on an odd word count.
REQ-015 ERR_CLR  in  1  synchronous clear of ERR_ODD.
REQ-016 PKT_CNT  out  CNT_W*N_SRC  per-source forwarded-packet counters.

Function
REQ-017 SHALL implement FSM IDLE, BUSY; packet-granular, no interleaving of sources.
REQ-018 IDLE: all S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_SRCDEST=0.
REQ-019 IDLE: candidates = S_AXIS_TVALID & SRC_EN; if nonzero, grant first candidate at or after round-robin pointer (wrapping mod N_SRC), register grant, go BUSY next cycle.
REQ-020 BUSY: M_AXIS_TDATA/TLAST/TVALID = granted source's signals combinationally; TREADY of granted source = M_AXIS_TREADY; all other TREADY=0.
REQ-021 BUSY: M_SRCDEST = SRCDEST_TBL[grant], stable for whole packet.
REQ-022 BUSY->IDLE on M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST; pointer <= grant+1 mod N_SRC.
REQ-023 One idle cycle SHALL separate consecutive packets (arbitration latency 1 cycle, pass-through latency 0).
REQ-024 SRC_EN deassertion of granted source during BUSY SHALL NOT abort packet; affects next arbitration only.
REQ-025 Word parity bit toggles per accepted beat in BUSY, cleared on entry to BUSY; TLAST beat with parity indicating odd count (1st, 3rd, ... word) SHALL set ERR_ODD[grant]; packet still forwarded.
REQ-026 ERR_CLR and a simultaneous set: set wins.
REQ-027 PKT_CNT[grant] SHALL increment on the TLAST transfer, wrapping to 0 at 2^CNT_W.
REQ-028 Single enabled requester SHALL be re-granted every packet.

Reset
REQ-029 On AXIS_ARESETN=0: state IDLE, pointer 0, grant 0, parity 0, ERR_ODD 0, PKT_CNT 0, all TREADY/TVALID/TLAST 0, M_SRCDEST 0.
REQ-030 Reset mid-packet SHALL abandon the packet; no recovery of partial data.

Structure
REQ-031 FSM state encodings and default widths SHALL live in shared package axis_pkg.
REQ-032 Round-robin selection SHALL be sub-module rr_pick (inputs req, ptr; output one-hot/index grant, valid), combinational.

Verification
REQ-033 Sources 0,2 valid at reset release, 4-word packets, ready=1 -> grant 0 then 2, one idle cycle gap, M_SRCDEST=TBL[0] then TBL[2].
REQ-034 All 4 sources continuously valid, 2-word packets -> grant order 0,1,2,3,0; PKT_CNT each =1 after first round.
REQ-035 M_AXIS_TREADY toggling 1/0 during 6-word packet from source 1 -> no data loss/duplication, S_AXIS_TREADY[1] mirrors M_AXIS_TREADY, others 0.
REQ-036 Source 3 sends 3-word packet -> ERR_ODD=4'b1000, packet forwarded; ERR_CLR pulse -> 0.
REQ-037 SRC_EN=4'b1101 with all valid -> source 1 never granted; deassert SRC_EN[0] mid-packet -> packet completes.
REQ-038 Reset asserted on word 2 of 4 -> outputs zero asynchronously; after release, next grant from pointer 0, counters 0.
